pulse_count_bank: RTL and testbench

Parametrised bank of edge-counting channels: the next-generation multi-channel pulse counter. Each of CH_NUM asynchronous-sourced pulse inputs is edge-detected and counted into a CNT_W-bit saturating counter, gated by a shared count enable. A snapshot command atomically latches all channels and restarts counting. Snapshots are read through a registered channel-select port, with a per-channel overflow flag. Sits between the pulse-generating front end and the register/readout logic.

---
 rtl/pulse_cnt_pkg.sv | 14 +
 rtl/pulse_cnt_ch.sv | 99 +++++++++
 rtl/pulse_count_bank.sv | 81 ++++++++
 tb/tb_pulse_count_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_cnt_pkg.sv
// Shared constants and helpers for the pulse counter bank.
// Edge-mode encodings and the read-select width function.
package pulse_cnt_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // A single-channel bank still gets a 1-bit select port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_cnt_ch.sv
// One counting channel: optional synchroniser, edge detect,
// saturating live counter, overflow flag and snapshot registers.
// Ports: clk_i, rst_i, pulse_i, en_i, clr_i, snap_i in;
// live_o, snap_cnt_o, snap_ovf_o out.
// Macro PULSE_CNT_SYNC_EN adds a two-flop input synchroniser.
module pulse_cnt_ch
  import pulse_cnt_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pulse_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] live_o,
  output logic [CNT_W-1:0] snap_cnt_o,
  output logic             snap_ovf_o
);

  // Rising mode idles high so a level held through reset
  // release never looks like an edge.
  localparam logic IDLE_LVL = (EDGE_MODE == EDGE_RISE);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic p;

`ifdef PULSE_CNT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {2{IDLE_LVL}};
    else       sync_q <= {sync_q[0], pulse_i};
  end

  assign p = sync_q[1];
`else
  assign p = pulse_i;
`endif

  logic             pulse_d_q;
  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;
  logic             sovf_q, sovf_d;
  logic             rise, fall, edg, inc;

  assign rise = p & ~pulse_d_q;
  assign fall = ~p & pulse_d_q;
  assign edg  = (EDGE_MODE == EDGE_FALL) ? fall :
                (EDGE_MODE == EDGE_BOTH) ? (rise | fall) :
                rise;
  assign inc  = edg & en_i;

  always_comb begin
    live_d = live_q;
    ovf_d  = ovf_q;
    snap_d = snap_q;
    sovf_d = sovf_q;
    if (clr_i) begin
      live_d = '0;
      ovf_d  = 1'b0;
      snap_d = '0;
      sovf_d = 1'b0;
    end else if (snap_i) begin
      // The coincident edge starts the new interval.
      snap_d = live_q;
      sovf_d = ovf_q;
      live_d = inc ? ONE : '0;
      ovf_d  = 1'b0;
    end else if (inc) begin
      if (&live_q) ovf_d  = 1'b1;
      else         live_d = live_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pulse_d_q <= IDLE_LVL;
      live_q    <= '0;
      ovf_q     <= 1'b0;
      snap_q    <= '0;
      sovf_q    <= 1'b0;
    end else begin
      pulse_d_q <= p;
      live_q    <= live_d;
      ovf_q     <= ovf_d;
      snap_q    <= snap_d;
      sovf_q    <= sovf_d;
    end
  end

  assign live_o     = live_q;
  assign snap_cnt_o = snap_q;
  assign snap_ovf_o = sovf_q;

endmodule

// File: rtl/pulse_count_bank.sv
// Bank of CH_NUM edge-counting channels with snapshot readout.
// Ports: clk, rst, pulse, en_count, clr, snap, rd_sel in;
// rd_data, rd_ovf, snap_valid, count_live out.
// Macro PULSE_CNT_SYNC_EN enables per-channel input synchronisers.
module pulse_count_bank
  import pulse_cnt_pkg::*;
#(
  parameter int CH_NUM    = 16,
  parameter int CNT_W     = 16,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         pulse,
  input  logic                      en_count,
  input  logic                      clr,
  input  logic                      snap,
  input  logic [sel_w(CH_NUM)-1:0]  rd_sel,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      rd_ovf,
  output logic                      snap_valid,
  output logic [CH_NUM*CNT_W-1:0]   count_live
);

  localparam int SW = sel_w(CH_NUM);

  logic [CNT_W-1:0]  snap_cnt [CH_NUM];
  logic [CH_NUM-1:0] snap_ovf;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pulse_cnt_ch #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (rst),
      .pulse_i    (pulse[i]),
      .en_i       (en_count),
      .clr_i      (clr),
      .snap_i     (snap),
      .live_o     (count_live[i*CNT_W +: CNT_W]),
      .snap_cnt_o (snap_cnt[i]),
      .snap_ovf_o (snap_ovf[i])
    );
  end

  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_ovf_q, rd_ovf_d;
  logic             sv_q, sv_d;

  // Unmatched selects (>= CH_NUM) fall through to zero.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (rd_sel == SW'(i)) begin
        rd_data_d = snap_cnt[i];
        rd_ovf_d  = snap_ovf[i];
      end
    end
  end

  assign sv_d = snap & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
      sv_q      <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
      sv_q      <= sv_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_ovf     = rd_ovf_q;
  assign snap_valid = sv_q;

endmodule

// File: tb/tb_pulse_count_bank.sv
// Scoreboard bench for pulse_count_bank: three builds
// (default, 4-bit saturating, 5-channel both-edge).
module tb_pulse_count_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_count, clr;
  logic [2:0]  snap;
  logic [15:0] p0;
  logic [3:0]  p1;
  logic [4:0]  p2;
  logic [3:0]  sel0;
  logic [1:0]  sel1;
  logic [2:0]  sel2;

  logic [15:0]  rd0;
  logic [3:0]   rd1;
  logic [7:0]   rd2;
  logic         ovf0, ovf1, ovf2;
  logic [2:0]   sv;
  logic [255:0] live0;
  logic [15:0]  live1;
  logic [39:0]  live2;

  pulse_count_bank dut0 (
    .clk(clk), .rst(rst), .pulse(p0), .en_count(en_count),
    .clr(clr), .snap(snap[0]), .rd_sel(sel0), .rd_data(rd0),
    .rd_ovf(ovf0), .snap_valid(sv[0]), .count_live(live0)
  );

  pulse_count_bank #(.CH_NUM(4), .CNT_W(4), .EDGE_MODE(0)) dut1 (
    .clk(clk), .rst(rst), .pulse(p1), .en_count(en_count),
    .clr(clr), .snap(snap[1]), .rd_sel(sel1), .rd_data(rd1),
    .rd_ovf(ovf1), .snap_valid(sv[1]), .count_live(live1)
  );

  pulse_count_bank #(.CH_NUM(5), .CNT_W(8), .EDGE_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .pulse(p2), .en_count(en_count),
    .clr(clr), .snap(snap[2]), .rd_sel(sel2), .rd_data(rd2),
    .rd_ovf(ovf2), .snap_valid(sv[2]), .count_live(live2)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        ovf;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  string   name_q[$];
  int      exp_snap [3];
  logic    rd_req = 1'b0;
  logic    rd_pipe = 1'b0;

  always @(posedge clk) rd_pipe <= rd_req;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: registered read responses and snap_valid strobes.
  always @(negedge clk) begin
    rd_exp_t     e;
    string       nm;
    logic [31:0] ad;
    logic        ao;
    if (rd_pipe) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e.dut)
          0:       begin ad = 32'(rd0); ao = ovf0; end
          1:       begin ad = 32'(rd1); ao = ovf1; end
          default: begin ad = 32'(rd2); ao = ovf2; end
        endcase
        chk({nm, "_data"}, ad, e.data);
        chk({nm, "_ovf"}, 32'(ao), 32'(e.ovf));
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (sv[d]) begin
        if (exp_snap[d] > 0) begin
          exp_snap[d]--;
          chk("snap_valid", 32'd1, 32'd1 & 32'(sv[d]));
        end else begin
          chk($sformatf("snap_valid_extra%0d", d), 32'd1, 32'd0);
        end
      end
    end
  end

  function automatic logic [31:0] live(int d, int c);
    case (d)
      0:       return 32'(live0[c*16 +: 16]);
      1:       return 32'(live1[c*4 +: 4]);
      default: return 32'(live2[c*8 +: 8]);
    endcase
  endfunction

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic setp(int d, int c, logic v);
    case (d)
      0:       p0[c] = v;
      1:       p1[c] = v;
      default: p2[c] = v;
    endcase
  endtask

  // n full pulses: high one cycle, low one cycle.
  task automatic pulses(int d, int c, int n);
    repeat (n) begin
      setp(d, c, 1'b1); cyc();
      setp(d, c, 1'b0); cyc();
    end
  endtask

  task automatic do_snap(int d);
    snap[d] = 1'b1;
    exp_snap[d]++;
    cyc();
    snap[d] = 1'b0;
  endtask

  task automatic rd(int d, int s, logic [31:0] e, logic eo,
                    string nm);
    rd_exp_t x;
    case (d)
      0:       sel0 = s[3:0];
      1:       sel1 = s[1:0];
      default: sel2 = s[2:0];
    endcase
    x.dut = d; x.data = e; x.ovf = eo;
    exp_q.push_back(x);
    name_q.push_back(nm);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    cyc();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) exp_snap[d] = 0;
    rst = 1'b1; en_count = 1'b0; clr = 1'b0; snap = '0;
    p0 = 16'h0001; p1 = '0; p2 = '0;
    sel0 = '0; sel1 = '0; sel2 = '0;
    cyc(3);
    chk("rst_rd_data", 32'(rd0), 32'd0);
    chk("rst_live0", 32'(|live0), 32'd0);
    chk("rst_sv", 32'(sv), 32'd0);
    rst = 1'b0;
    en_count = 1'b1;
    cyc(3);
    chk("level_at_release", live(0, 0), 32'd0);

    // Basic count
    setp(0, 0, 1'b0); cyc();
    pulses(0, 0, 5);
    chk("basic_live_ch0", live(0, 0), 32'd5);
    chk("basic_live_ch1", live(0, 1), 32'd0);
    do_snap(0);
    chk("basic_live_after_snap", live(0, 0), 32'd0);
    rd(0, 0, 5, 1'b0, "basic_rd0");
    rd(0, 1, 0, 1'b0, "basic_rd1");

    // Gate, plus re-enable with level already high
    en_count = 1'b0;
    pulses(0, 0, 3);
    setp(0, 0, 1'b1); cyc();
    en_count = 1'b1; cyc(2);
    setp(0, 0, 1'b0); cyc();
    chk("gate_reenable_high", live(0, 0), 32'd0);
    pulses(0, 0, 4);
    chk("gate_live", live(0, 0), 32'd4);

    // Saturation on the 4-bit build
    pulses(1, 0, 18);
    chk("sat_live", live(1, 0), 32'd15);
    do_snap(1);
    chk("sat_live_after_snap", live(1, 0), 32'd0);
    rd(1, 0, 15, 1'b1, "sat_rd");
    pulses(1, 0, 2);
    do_snap(1);
    rd(1, 0, 2, 1'b0, "sat_ovf_cleared");

    // Snapshot with coincident edge
    pulses(0, 2, 7);
    chk("coinc_live_pre", live(0, 2), 32'd7);
    setp(0, 2, 1'b1);
    do_snap(0);
    chk("coinc_live_post", live(0, 2), 32'd1);
    setp(0, 2, 1'b0); cyc();
    rd(0, 2, 7, 1'b0, "coinc_snap");
    rd(0, 0, 4, 1'b0, "coinc_snap_ch0");

    // clr beats snap
    pulses(0, 2, 8);
    chk("clr_live_pre", live(0, 2), 32'd9);
    clr = 1'b1; snap[0] = 1'b1;
    cyc();
    clr = 1'b0; snap[0] = 1'b0;
    chk("clr_live", live(0, 2), 32'd0);
    cyc();
    rd(0, 2, 0, 1'b0, "clr_snap_ch2");
    rd(0, 0, 0, 1'b0, "clr_snap_ch0");

    // Channel sweep, both edges, 5-channel build
    for (int i = 0; i < 5; i++) pulses(2, i, i + 1);
    chk("sweep_live4", live(2, 4), 32'd10);
    do_snap(2);
    for (int i = 0; i < 5; i++)
      rd(2, i, 32'(2 * (i + 1)), 1'b0, $sformatf("sweep_rd%0d", i));
    rd(2, 5, 0, 1'b0, "sweep_oob5");
    rd(2, 7, 0, 1'b0, "sweep_oob7");

    cyc(2);
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    for (int d = 0; d < 3; d++)
      chk($sformatf("snap_seen%0d", d), 32'(exp_snap[d]), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
